mdu_unit: RTL and testbench
===========================

# mdu_unit

Parametrised multiply/divide unit holding the HI/LO register pair for the execute stage of the pipelined MIPS core. It supports signed and unsigned multiply, divide and multiply-accumulate/subtract (MADD/MADDU/MSUB/MSUBU). Multiply latency is configurable. Divide is a true iterative restoring divider. In-flight operations can be cancelled by an exception flush. The hazard unit stalls any HI/LO consumer while `busy` is high.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width (>= 8)
- MUL_LAT, 5, multiply/accumulate busy cycles (1..15)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- start  in  1  request to launch `op` this cycle
- op  in  4  operation code (mdu_pkg encoding)
- rs_val  in  WIDTH  operand A (dividend / multiplicand)
- rt_val  in  WIDTH  operand B (divisor / multiplier)
- mt_we  in  1  MTHI/MTLO write enable
- mt_sel  in  1  0 = HI, 1 = LO
- mt_data  in  WIDTH  MTHI/MTLO data
- flush  in  1  abort in-flight op (exception/eret)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, HI/LO just updated by an op
- div_zero  out  1  valid with `done`; the completed op was a divide by zero

## Operation
- Reset values: hi=0, lo=0, busy=0, done=0, div_zero=0, internal counters and datapath 0.
- Accept: start=1, busy=0, flush=0, op valid → latch operands and op, busy=1 next cycle. Invalid op codes are ignored.
- start while busy=1 or flush=1 is ignored.
- MTHI/MTLO: mt_we=1, busy=0, start=0 → selected register <= mt_data. mt_we in the same cycle as an accepted start is dropped; start wins. mt_we while busy is ignored.
- MULT/MULTU: {hi,lo} <= full 2·WIDTH product, signed or unsigned.
- MADD/MADDU/MSUB/MSUBU: {hi,lo} <= {hi,lo} ± product, modulo 2^(2·WIDTH). {hi,lo} is read at the completion edge; it cannot change while busy.
- DIV/DIVU: lo <= quotient, hi <= remainder.
  - Signed divide operates on magnitudes. Quotient is negated if operand signs differ. Remainder takes the dividend's sign (truncating division).
  - Divide by zero: lo <= all-ones, hi <= rs_val, div_zero=1 with done.
  - Signed MIN / −1: lo <= MIN, hi <= 0, no flag.
- Flush: any flush=1 cycle while busy aborts the op. hi/lo are unchanged, busy=0 next cycle, no done pulse.
- div_zero is 0 whenever done=0.

## Timing
- Accept edge E0. Multiply-class ops: hi/lo are written and busy falls at edge E(MUL_LAT). busy is high for exactly MUL_LAT cycles.
- Divide: WIDTH iteration cycles plus 1 sign-fixup cycle. Result written at E(WIDTH+1). busy is high for WIDTH+1 cycles (33 at WIDTH=32).
- Divide by zero: same latency as a normal divide; no early exit.
- done is high during the cycle following the write edge. A new start is accepted in that same cycle (back-to-back).
- hi/lo outputs come directly from registers and carry no combinational path from inputs.
- Asynchronous reset asserted mid-operation: all outputs return to reset values without waiting for a clock. After release the unit is idle.
- FSM states:
  - IDLE: start accepted → MUL (multiply-class op) or DIV (divide op).
  - MUL: counter reaches MUL_LAT → WRITE.
  - DIV: counter reaches WIDTH → FIX.
  - FIX → WRITE.
  - WRITE → IDLE; done pulse is asserted here.
  - Any state → IDLE on flush.
  - busy is high in MUL, DIV, FIX and WRITE-entry as counted above.

## Structure
- mdu_pkg:
  - mdu_op_t encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MADDU=5, MSUB=6, MSUBU=7
  - FSM state enum
  - is_div and is_signed helper functions
- Sub-module mdu_divider: one-bit-per-cycle restoring divider, parameterised by WIDTH.
  - Inputs: magnitudes, load, step, flush.
  - Outputs: quotient and remainder magnitudes.
  - mdu_unit owns sign handling, the divide-by-zero override, the FSM and HI/LO.
- Multiply: behavioural product computed at accept, held in a register, committed after the MUL_LAT counter expires. Synthesis retimes it.

## Test plan
- MULT rs=0xFFFFFFFE, rt=0x00000003 → after 5 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=−7 (0xFFFFFFF9), rt=2 → busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- DIVU rs=0x1234, rt=0 → lo=0xFFFFFFFF, hi=0x1234, div_zero=1 with done. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- MTHI 1, MTLO 0xFFFFFFFF, then MADDU 1×1 → hi=2, lo=0. Then MSUB 1×1 → hi=1, lo=0xFFFFFFFF.
- Flush the cycle after a DIV is accepted → busy=0 next cycle, hi/lo unchanged, no done. A start issued during busy is ignored. start and mt_we together at idle → op runs and the mt write is dropped.
- Drive reset low mid-DIV, between clock edges → outputs are 0 immediately. After release, MULT 3×4 at MUL_LAT=1 → lo=12 one cycle later.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and decode helpers
// shared by the multiply/divide unit and its divider.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7
  } mdu_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_WRITE
  } mdu_state_t;

  function automatic logic is_valid(input logic [3:0] op);
    return !op[3];
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Even codes are the signed variants.
  function automatic logic is_signed(input logic [3:0] op);
    return !op[0];
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
    return op[2];
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: unsigned restoring divider, one quotient
// bit per step; operates on magnitudes only.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;

  assign shl    = {rem_q, quo_q[WIDTH-1]};
  assign diff   = shl - {1'b0, dvs_q};
  assign quot_o = quo_q;
  assign rem_o  = rem_q;

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (flush_i) begin
      quo_d = '0;
      rem_d = '0;
      dvs_d = '0;
    end else if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
    end else if (step_i) begin
      // diff[WIDTH] set means the trial subtract went negative.
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shl[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: HI/LO multiply/divide unit for the execute stage.
// Multiply commits a held product; divide is iterative.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mt_we,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  mdu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic             acc_q, acc_d;
  logic             sub_q, sub_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;

  logic             accept, sgn;
  logic             div_load, div_step;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] quo_mag, rem_mag;
  logic [W2-1:0]    a_ext, b_ext;
  logic [W2-1:0]    acc_hl, mul_res;

  assign busy     = state_q inside {S_MUL, S_DIV, S_FIX};
  assign done     = (state_q == S_WRITE);
  assign div_zero = done & dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  assign sgn    = is_signed(op);
  assign accept = start & ~busy & ~flush & is_valid(op);
  assign a_mag  = (sgn & rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign b_mag  = (sgn & rt_val[WIDTH-1]) ? -rt_val : rt_val;
  assign a_ext  = {{WIDTH{sgn & rs_val[WIDTH-1]}}, rs_val};
  assign b_ext  = {{WIDTH{sgn & rt_val[WIDTH-1]}}, rt_val};
  assign acc_hl = {hi_q, lo_q};
  assign mul_res = !acc_q ? prod_q :
                   sub_q  ? acc_hl - prod_q :
                            acc_hl + prod_q;
  assign div_load = accept & is_div(op);

  mdu_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (div_load),
    .step_i    (div_step),
    .flush_i   (flush),
    .dividend_i(a_mag),
    .divisor_i (b_mag),
    .quot_o    (quo_mag),
    .rem_o     (rem_mag)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    rs_d     = rs_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    sub_d    = sub_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    div_step = 1'b0;
    unique case (state_q)
      S_IDLE, S_WRITE: begin
        state_d = S_IDLE;
        if (accept) begin
          cnt_d  = CW'(1);
          acc_d  = is_acc(op);
          sub_d  = is_sub(op);
          dz_d   = is_div(op) & (rt_val == '0);
          qneg_d = sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
          rneg_d = sgn & rs_val[WIDTH-1];
          rs_d   = rs_val;
          if (is_div(op)) begin
            state_d = S_DIV;
          end else begin
            state_d = S_MUL;
            prod_d  = a_ext * b_ext;
          end
        end else if (mt_we && !start) begin
          if (mt_sel) lo_d = mt_data;
          else        hi_d = mt_data;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_LAT)) begin
          state_d      = S_WRITE;
          {hi_d, lo_d} = mul_res;
        end
      end
      S_DIV: begin
        div_step = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_WRITE;
        if (dz_q) begin
          hi_d = rs_q;
          lo_d = '1;
        end else begin
          hi_d = rneg_q ? -rem_mag : rem_mag;
          lo_d = qneg_q ? -quo_mag : quo_mag;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush && busy) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rs_q    <= '0;
      prod_q  <= '0;
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rs_q    <= rs_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      sub_q   <= sub_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors with a result scoreboard
// drained by done-driven monitors.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         mt_we = 1'b0;
  logic         mt_sel = 1'b0;
  logic [W-1:0] mt_data = '0;
  logic         flush = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_zero;

  logic         start1 = 1'b0;
  logic [3:0]   op1 = '0;
  logic [W-1:0] rs1 = '0;
  logic [W-1:0] rt1 = '0;
  logic [W-1:0] hi1, lo1;
  logic         busy1, done1, dz1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mdu_unit #(.WIDTH(W), .MUL_LAT(5)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mt_we   (mt_we),
    .mt_sel  (mt_sel),
    .mt_data (mt_data),
    .flush   (flush),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero)
  );

  mdu_unit #(.WIDTH(W), .MUL_LAT(1)) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .start   (start1),
    .op      (op1),
    .rs_val  (rs1),
    .rt_val  (rt1),
    .mt_we   (1'b0),
    .mt_sel  (1'b0),
    .mt_data ('0),
    .flush   (1'b0),
    .hi      (hi1),
    .lo      (lo1),
    .busy    (busy1),
    .done    (done1),
    .div_zero(dz1)
  );

  always @(negedge clk) begin
    checks++;
    if (done) begin
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done hi=%h lo=%h", hi, lo);
      end else begin
        e0 = q.pop_front();
        if ({hi, lo, div_zero} !== {e0.hi, e0.lo, e0.dz}) begin
          failures++;
          $display("FAIL result got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                   hi, lo, div_zero, e0.hi, e0.lo, e0.dz);
        end
      end
    end else if (div_zero !== 1'b0) begin
      failures++;
      $display("FAIL dz_without_done got=%b want=0", div_zero);
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done1 hi=%h lo=%h", hi1, lo1);
      end else begin
        e1 = q1.pop_front();
        if ({hi1, lo1, dz1} !== {e1.hi, e1.lo, e1.dz}) begin
          failures++;
          $display("FAIL result1 got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                   hi1, lo1, dz1, e1.hi, e1.lo, e1.dz);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [W-1:0] got,
                       input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_lat(input string nm, input int want);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != want) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=%0d", nm, n, want);
    end
  endtask

  task automatic run_op(input string nm, input logic [3:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edz, input int lat);
    q.push_back('{ehi, elo, edz});
    issue(o, a, b);
    wait_lat(nm, lat);
  endtask

  task automatic mt(input logic sel, input logic [W-1:0] d);
    mt_we   = 1'b1;
    mt_sel  = sel;
    mt_data = d;
    @(posedge clk);
    #1 mt_we = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_ctl", W'({busy, done, div_zero}), '0);
    #11 reset = 1'b1;

    run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 5);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3,
           32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 5);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("divu", OP_DIVU, 32'd100, 32'd7,
           32'd2, 32'd14, 1'b0, 33);
    run_op("divu_zero", OP_DIVU, 32'h1234, 32'd0,
           32'h1234, 32'hFFFF_FFFF, 1'b1, 33);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, 1'b0, 33);

    mt(1'b0, 32'd1);
    mt(1'b1, 32'hFFFF_FFFF);
    check("mthi", hi, 32'd1);
    check("mtlo", lo, 32'hFFFF_FFFF);
    run_op("maddu", OP_MADDU, 32'd1, 32'd1,
           32'd2, 32'd0, 1'b0, 5);
    run_op("msub", OP_MSUB, 32'd1, 32'd1,
           32'd1, 32'hFFFF_FFFF, 1'b0, 5);

    issue(OP_DIV, 32'd100, 32'd7);
    check("flush_pre_busy", W'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", W'(busy), 32'd0);
    repeat (40) @(negedge clk);
    check("flush_hi", hi, 32'd1);
    check("flush_lo", lo, 32'hFFFF_FFFF);

    q.push_back('{32'd0, 32'd6, 1'b0});
    issue(OP_MULT, 32'd2, 32'd3);
    @(negedge clk);
    start  = 1'b1;
    op     = OP_DIVU;
    rs_val = 32'd5;
    rt_val = 32'd0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_lat("busy_start", 4);
    repeat (3) @(negedge clk);
    check("ignored_start", W'(busy), 32'd0);

    q.push_back('{32'd0, 32'd21, 1'b0});
    mt_we   = 1'b1;
    mt_sel  = 1'b1;
    mt_data = 32'hDEAD_BEEF;
    issue(OP_MADDU, 32'd3, 32'd5);
    mt_we = 1'b0;
    wait_lat("start_mt", 5);

    start = 1'b1;
    op    = 4'hF;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("bad_op_busy", W'(busy), 32'd0);
    check("bad_op_lo", lo, 32'd21);

    issue(OP_DIV, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_hi", hi, '0);
    check("async_lo", lo, '0);
    check("async_ctl", W'({busy, done, div_zero}), '0);
    #3 reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", W'(busy), 32'd0);

    q1.push_back('{32'd0, 32'd12, 1'b0});
    start1 = 1'b1;
    op1    = OP_MULT;
    rs1    = 32'd3;
    rt1    = 32'd4;
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);
    check("lat1_busy", W'(busy1), 32'd1);
    @(negedge clk);
    check("lat1_idle", W'(busy1), 32'd0);
    check("lat1_lo", lo1, 32'd12);

    run_op("mult_post_rst", OP_MULT, 32'd3, 32'd4,
           32'd0, 32'd12, 1'b0, 5);
    repeat (3) @(negedge clk);
    check("queue_left", W'(q.size()), 32'd0);
    check("queue1_left", W'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
